wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have clk_i  in  1  single clock; all state updates on posedge clk_i.
REQ-002 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have alu_valid_i  in  1  ALU result present this cycle; no backpressure, always accepted.
REQ-004 SHALL have alu_rd_i  in  5  ALU destination register.
REQ-005 SHALL have alu_data_i  in  32  ALU result.
REQ-006 SHALL have ld_valid_i  in  1  load response present.
REQ-007 SHALL have ld_ready_o  out  1  load response acceptable this cycle.
REQ-008 SHALL have ld_rd_i  in  5  load destination register.
REQ-009 SHALL have ld_data_i  in  32  load data.
REQ-010 SHALL have RDaddr_o  out  5  register-file write address, registered.
REQ-011 SHALL have RDdata_o  out  32  register-file write data, registered.
REQ-012 SHALL have RegWrite_o  out  1  register-file write enable, registered.
REQ-013 SHALL have ld_count_o  out  2  load buffer occupancy (0..2).

Function
REQ-014 Load accepted SHALL be defined as ld_valid_i && ld_ready_o at the clock edge.
REQ-015 ld_ready_o SHALL be 1 when the buffer count is below 2 and rst_i is low, otherwise 0; it is computed from registered count only, with no dependency on the same-cycle dequeue.
REQ-016 The buffer SHALL be a 2-entry in-order FIFO with states EMPTY (0), ONE (1), and FULL (2); enqueue and dequeue in the same cycle leave the count unchanged.
REQ-017 Per cycle, output-select priority SHALL be: (1) ALU write when alu_valid_i && alu_rd_i != 0; (2) buffer head; (3) nothing.
REQ-018 The selected source SHALL appear on RDaddr_o, RDdata_o, and RegWrite_o=1 one cycle after the selecting edge; otherwise RegWrite_o=0, and RDaddr_o and RDdata_o hold their previous values.
REQ-019 A write to x0 (rd==0) from either source SHALL never assert RegWrite_o; such an ALU input is ignored, and such a load is accepted and dropped.
REQ-020 Kill rule: an ALU write with rd!=0 SHALL invalidate every buffered entry with the same rd in that cycle.
REQ-021 A load accepted in the same cycle as an ALU write to the same rd SHALL be treated as older, and SHALL be accepted and dropped.
REQ-022 When the buffer head is invalidated, it SHALL be popped in the next cycle not used by an ALU write, with RegWrite_o=0, consuming one cycle.
REQ-023 Buffer entries SHALL drain strictly in arrival order, and valid loads SHALL never reorder with respect to each other.
REQ-024 Without the bypass feature, load latency SHALL be accept edge + 2 cycles to RegWrite_o when no ALU write intervenes.
REQ-025 Each ALU cycle SHALL stall the buffer drain by exactly one cycle, and a FULL buffer SHALL hold ld_ready_o=0 until a pop occurs.

Reset
REQ-026 While rst_i is high at an edge, the block SHALL set RegWrite_o=0, RDaddr_o=0, RDdata_o=0, count=0, and all entry valid bits=0.
REQ-027 While rst_i is high, ld_ready_o SHALL be 0.
REQ-028 Reset mid-drain SHALL discard buffered loads without any write.
REQ-029 ALU inputs in a reset cycle SHALL be ignored.

Configuration
REQ-030 The macro WB_LOAD_BYPASS_EN, when defined, SHALL route a valid accepted load with rd!=0 directly to the output registers, without enqueueing, when no ALU write occurs and the buffer is empty that cycle, giving 1-cycle latency.
REQ-031 When WB_LOAD_BYPASS_EN is undefined, every accepted load SHALL pass through the buffer, giving a minimum 2-cycle latency; all other behaviour is identical.

Structure
REQ-032 Package wb_pkg SHALL hold the WB_BUF_DEPTH=2 constant and the buffer entry typedef {valid, rd[4:0], data[31:0]}.
REQ-033 Sub-module wb_load_buf SHALL implement the 2-entry FIFO with a per-entry rd-match kill port.
REQ-034 wb_arbiter SHALL hold the priority mux, the bypass logic, and the output registers.

Verification
REQ-035 Reset check: reset with ld_valid_i=1 -> RegWrite_o=0, ld_ready_o=0, ld_count_o=0 throughout; ld_ready_o=1 on the first cycle after release.
REQ-036 ALU only: ALU rd=5 data=0x11 -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0x11 the next cycle; ALU rd=0 -> no write.
REQ-037 Load only (no bypass): load rd=7 data=0xAA -> write of rd 7 at accept+2; with WB_LOAD_BYPASS_EN -> write at accept+1.
REQ-038 Back-pressure: ALU active for 4 cycles while 3 loads arrive -> ld_ready_o drops after 2 accepts, the third load waits, and writes come out in order rd 1, 2, 3 after the ALU burst.
REQ-039 Kill: buffered load rd=9, then ALU rd=9 data=0x55 -> only the 0x55 write to rd 9 occurs, and the killed entry pops with RegWrite_o=0.
REQ-040 Same-cycle rd clash: ALU rd=3 and load rd=3 accepted in the same cycle -> single write of ALU data, and ld_count_o remains 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the register-file write-back arbiter.
//   WB_BUF_DEPTH : number of load-buffer entries
//   wb_entry_t   : one buffered load {valid, rd, data}; valid=0 marks a killed entry
package wb_pkg;
    localparam int          WB_BUF_DEPTH = 2;
    localparam logic [1:0]  WB_CNT_FULL  = 2'(WB_BUF_DEPTH);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_buf.sv
// wb_load_buf: 2-entry in-order load buffer with rd-match kill.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i/_rd_i/_data_i : enqueue a load (caller guarantees space)
//   pop_i              : dequeue head (ignored when empty)
//   kill_i/kill_rd_i   : invalidate every occupied entry whose rd matches
//   head_o             : current head entry (entry 0)
//   count_o            : occupancy 0..2 (killed entries still occupy a slot)
module wb_load_buf
    import wb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [4:0]       push_rd_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    input  logic             kill_i,
    input  logic [4:0]       kill_rd_i,
    output wb_entry_t        head_o,
    output logic [1:0]       count_o
);
    wb_entry_t [WB_BUF_DEPTH-1:0] ent_q, ent_d;
    logic [1:0]                   cnt_q, cnt_d;

    // Kill first, then shift on pop, then write the new entry behind the
    // surviving ones so arrival order is preserved.
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WB_BUF_DEPTH; i++) begin
            if (kill_i && ent_d[i].valid && ent_d[i].rd == kill_rd_i)
                ent_d[i].valid = 1'b0;
        end
        if (pop_i && cnt_q != 2'd0) begin
            ent_d[0] = ent_d[1];
            ent_d[1] = '0;
            cnt_d    = cnt_q - 2'd1;
        end
        if (push_i && cnt_d < WB_CNT_FULL) begin
            ent_d[cnt_d[0]] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
            cnt_d           = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges an unstallable ALU result stream and a load-response
// stream into one registered register-file write port.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   alu_valid_i/_rd_i/_data_i    : ALU result, always accepted, highest priority
//   ld_valid_i/_rd_i/_data_i     : load response, ld_ready_o handshake
//   RDaddr_o/RDdata_o/RegWrite_o : registered register-file write port
//   ld_count_o                   : load buffer occupancy
// Option: define WB_LOAD_BYPASS_EN to let a load skip the empty buffer when
// no ALU write is present (1-cycle latency instead of 2).
module wb_arbiter
    import wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        RegWrite_o,
    output logic [1:0]  ld_count_o
);
    wb_entry_t   head;
    logic [1:0]  count;
    logic        alu_w, ld_acc, ld_keep, bypass, push, pop;
    logic [4:0]  RDaddr_q, RDaddr_d;
    logic [31:0] RDdata_q, RDdata_d;
    logic        RegWrite_q, RegWrite_d;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign ld_ready_o = !rst_i && (count < WB_CNT_FULL);
    assign ld_acc     = ld_valid_i && ld_ready_o;
    assign alu_w      = !rst_i && alu_valid_i && (alu_rd_i != 5'd0);

    // An accepted load to x0, or one clashing with a same-cycle ALU write
    // (the load is the older value), is consumed but never stored.
    assign ld_keep = ld_acc && (ld_rd_i != 5'd0) && !(alu_w && ld_rd_i == alu_rd_i);

`ifdef WB_LOAD_BYPASS_EN
    assign bypass = ld_keep && !alu_w && (count == 2'd0);
`else
    assign bypass = 1'b0;
`endif

    assign push = ld_keep && !bypass;
    // Head drains on any non-ALU cycle; a killed head still costs its cycle.
    assign pop  = !rst_i && !alu_w && (count != 2'd0);

    wb_load_buf u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_rd_i   (ld_rd_i),
        .push_data_i (ld_data_i),
        .pop_i       (pop),
        .kill_i      (alu_w),
        .kill_rd_i   (alu_rd_i),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        RegWrite_d = 1'b0;
        RDaddr_d   = RDaddr_q;
        RDdata_d   = RDdata_q;
        if (alu_w) begin
            RegWrite_d = 1'b1;
            RDaddr_d   = alu_rd_i;
            RDdata_d   = alu_data_i;
        end else if (pop && head.valid) begin
            RegWrite_d = 1'b1;
            RDaddr_d   = head.rd;
            RDdata_d   = head.data;
        end else if (bypass) begin
            RegWrite_d = 1'b1;
            RDaddr_d   = ld_rd_i;
            RDdata_d   = ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegWrite_q <= 1'b0;
            RDaddr_q   <= 5'd0;
            RDdata_q   <= 32'd0;
        end else begin
            RegWrite_q <= RegWrite_d;
            RDaddr_q   <= RDaddr_d;
            RDdata_q   <= RDdata_d;
        end
    end

    assign RegWrite_o = RegWrite_q;
    assign RDaddr_o   = RDaddr_q;
    assign RDdata_o   = RDdata_q;
    assign ld_count_o = count;
endmodule
